// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and constants for the bit-serial adder/subtractor.
//   state_e  : control FSM states (IDLE, RUN, DONE)
//   MODE_ADD : value of 'sub' selecting addition
//   MODE_SUB : value of 'sub' selecting subtraction
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder built from two half adders and an OR gate.
//   a, b, cin : input bits
//   sum       : a XOR b XOR cin
//   cout      : majority(a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (sum),
    .c (c1)
  );

  // The two half-adder carries can never both be 1, so OR is exact.
  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
// One-bit half adder cell.
//   a, b : input bits
//   s    : a XOR b
//   c    : a AND b
// -----------------------------------------------------------------------------
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder/subtractor: one full-adder cell processes one bit per clock,
// LSB first. One result every WIDTH+1 cycles with a start/busy/done handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin an operation (accepted in IDLE or DONE)
//   sub        : 0 = a + b + cin, 1 = a - b (cin ignored)
//   a, b       : operands, sampled with start
//   busy       : operation in progress
//   done       : one-cycle pulse, sum/cout/ovf valid
//   sum        : result, held until the next completion
//   cout       : carry out (for subtract, 1 = no borrow)
//   ovf        : two's-complement overflow
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  // Holds the low WIDTH-1 sum bits; the MSB comes straight from the cell on
  // the last cycle, so no extra shift is needed when loading sum.
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          opa_d   = a;
          // Subtract is a + ~b + 1: invert b and force the initial carry.
          opb_d   = (sub == MODE_SUB) ? ~b : b;
          carry_d = (sub == MODE_SUB) ? 1'b1 : cin;
        end
      end
      RUN: begin
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        carry_d = fa_cout;
        res_d   = (WIDTH-1)'({fa_sum, res_q} >> 1);
        if (cnt_q == LAST_BIT) begin
          // MSB cycle: carry_q is the carry into the MSB, fa_cout the carry out.
          state_d = DONE;
          done_d  = 1'b1;
          sum_d   = {fa_sum, res_q};
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
        end else begin
          busy_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH = 8 instance
  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  // Parameter-sweep instances share one stimulus bus
  logic        startw = 1'b0, subw = 1'b0, cinw = 1'b0;
  logic [15:0] aw = '0, bw = '0;
  logic        busy2, done2, cout2, ovf2;
  logic [1:0]  sum2;
  logic        busy5, done5, cout5, ovf5;
  logic [4:0]  sum5;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(startw), .sub(subw), .a(aw[1:0]), .b(bw[1:0]),
    .cin(cinw), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  serial_adder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(startw), .sub(subw), .a(aw[4:0]), .b(bw[4:0]),
    .cin(cinw), .busy(busy5), .done(done5), .sum(sum5), .cout(cout5), .ovf(ovf5));

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(startw), .sub(subw), .a(aw), .b(bw),
    .cin(cinw), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));

  int n_asserts = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Launch one WIDTH=8 operation and wait for done; lat counts the start edge as 1.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic c, output int lat);
    a8 = a; b8 = b; sub8 = s; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 1;
    chk("busy_after_start", busy8, 1'b1);
    while (!done8 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // Reference: plain integer arithmetic, no serial structure.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic s, input logic c, output logic [15:0] r,
                                output logic co, output logic ov);
    logic [16:0] full;
    logic [15:0] mask, am, bm;
    logic sa, sb, sr;
    mask = 16'((32'd1 << w) - 1);
    am = a & mask;
    bm = b & mask;
    if (!s) full = {1'b0, am} + {1'b0, bm} + {16'd0, c};
    else    full = {1'b0, am} - {1'b0, bm};
    r  = full[15:0] & mask;
    co = s ? (am >= bm) : full[w];
    sa = am[w-1]; sb = bm[w-1]; sr = r[w-1];
    ov = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
  endfunction

  task automatic sweep(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic c);
    int t, l2, l5, l16;
    logic [1:0] s2; logic [4:0] s5; logic [15:0] s16;
    logic co2, ov2, co5, ov5, co16, ov16;
    logic [15:0] r; logic eco, eov;
    aw = a; bw = b; subw = s; cinw = c; startw = 1'b1;
    tick();
    startw = 1'b0;
    t = 1; l2 = 0; l5 = 0; l16 = 0;
    s2 = '0; s5 = '0; s16 = '0;
    co2 = 0; ov2 = 0; co5 = 0; ov5 = 0; co16 = 0; ov16 = 0;
    while ((l2 == 0 || l5 == 0 || l16 == 0) && t < 30) begin
      tick();
      t++;
      if (done2 && l2 == 0) begin l2 = t; s2 = sum2; co2 = cout2; ov2 = ovf2; end
      if (done5 && l5 == 0) begin l5 = t; s5 = sum5; co5 = cout5; ov5 = ovf5; end
      if (done16 && l16 == 0) begin l16 = t; s16 = sum16; co16 = cout16; ov16 = ovf16; end
    end
    model(2, a, b, s, c, r, eco, eov);
    chk("w2_sum", {30'd0, s2}, {16'd0, r}); chk("w2_cout", co2, eco);
    chk("w2_ovf", ov2, eov); chk("w2_lat", l2, 3);
    model(5, a, b, s, c, r, eco, eov);
    chk("w5_sum", {27'd0, s5}, {16'd0, r}); chk("w5_cout", co5, eco);
    chk("w5_ovf", ov5, eov); chk("w5_lat", l5, 6);
    model(16, a, b, s, c, r, eco, eov);
    chk("w16_sum", {16'd0, s16}, {16'd0, r}); chk("w16_cout", co16, eco);
    chk("w16_ovf", ov16, eov); chk("w16_lat", l16, 17);
    tick();
  endtask

  initial begin
    int lat;
    int pulses;

    //             a      b      sub   cin   sum    cout  ovf
    vecs[0] = '{8'h3C, 8'h55, 1'b0, 1'b0, 8'h91, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{8'h7F, 8'h7F, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[8] = '{8'h55, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

    // Reset held with random inputs toggling
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      sub8 = 1'($urandom); cin8 = 1'($urandom);
      startw = 1'($urandom); aw = 16'($urandom);
      tick();
      chk("rst_busy", busy8, 1'b0);
      chk("rst_done", done8, 1'b0);
      chk("rst_sum", sum8, 8'h00);
      chk("rst_cout", cout8, 1'b0);
      chk("rst_ovf", ovf8, 1'b0);
    end
    start8 = 1'b0; startw = 1'b0;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done8 || busy8) pulses++;
    end
    chk("idle_no_activity", pulses, 0);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat);
      chk($sformatf("vec%0d_lat", i), lat, 9);
      chk($sformatf("vec%0d_sum", i), sum8, vecs[i].s);
      chk($sformatf("vec%0d_cout", i), cout8, vecs[i].co);
      chk($sformatf("vec%0d_ovf", i), ovf8, vecs[i].ov);
      chk($sformatf("vec%0d_busy_in_done", i), busy8, 1'b0);
      tick();
      chk($sformatf("vec%0d_done_pulse", i), done8, 1'b0);
    end

    // Start pulsed during RUN is ignored
    a8 = 8'h3C; b8 = 8'h55; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 1;
    tick(); tick(); lat = 3;
    a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b1; start8 = 1'b1;
    tick(); lat++;
    start8 = 1'b0; a8 = 8'h00;
    while (!done8 && lat < 40) begin
      tick();
      lat++;
    end
    chk("ign_lat", lat, 9);
    chk("ign_sum", sum8, 8'h91);
    chk("ign_ovf", ovf8, 1'b1);

    // Back-to-back: start accepted in the DONE cycle
    op8(8'h10, 8'h20, 1'b1, 1'b0, lat);
    chk("b2b_lat", lat, 9);
    chk("b2b_sum", sum8, 8'hF0);
    chk("b2b_cout", cout8, 1'b0);

    // Result holds while idle
    for (int i = 0; i < 5; i++) tick();
    chk("hold_sum", sum8, 8'hF0);
    chk("hold_done", done8, 1'b0);
    chk("hold_busy", busy8, 1'b0);

    // Reset mid-RUN
    a8 = 8'h3C; b8 = 8'h55; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy8, 1'b0);
    chk("midrst_done", done8, 1'b0);
    chk("midrst_sum", sum8, 8'h00);
    chk("midrst_cout", cout8, 1'b0);
    chk("midrst_ovf", ovf8, 1'b0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    op8(8'h01, 8'h01, 1'b0, 1'b0, lat);
    chk("postrst_lat", lat, 9);
    chk("postrst_sum", sum8, 8'h02);

    // Parameter sweep: WIDTH 2, 5, 16 in both modes
    sweep(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    sweep(16'h0000, 16'hFFFF, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      sweep(16'($urandom), 16'($urandom), 1'(i % 2), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor: adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, reusing a single full-adder cell and a carry flip-flop. It is the area-minimal successor to the combinational half-adder cell. It serves datapaths where throughput of one result per WIDTH+1 cycles is acceptable, and uses a start/busy/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a new operation; sampled only when busy = 0
- sub  input  1  0 = add, 1 = subtract; sampled with start
- a  input  WIDTH  first operand; sampled with start
- b  input  WIDTH  second operand; sampled with start
- cin  input  1  carry-in for add; ignored when sub = 1
- busy  output  1  operation in progress
- done  output  1  single-cycle pulse; result valid
- sum  output  WIDTH  result; holds until the next completion
- cout  output  1  carry-out; for subtract, 1 = no borrow
- ovf  output  1  two's-complement overflow, computed as the carry into the MSB XOR the carry out of the MSB

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: processing one bit per cycle.
  - DONE: one cycle; done = 1.
- IDLE/DONE -> RUN when start = 1. On that edge:
  - Load operand shift registers with a and (sub ? ~b : b).
  - Set the carry register to (sub ? 1 : cin).
  - Clear the bit counter.
- In RUN, each cycle:
  - The full-adder cell takes the current LSB of each operand register and the carry register.
  - The sum bit shifts into the MSB of the internal result register, which shifts right.
  - The operand registers shift right and the carry register updates.
  - The counter increments.
  - On the MSB cycle (counter = WIDTH-1), capture the carry-in of that bit for ovf.
- RUN -> DONE after WIDTH cycles. On that edge, sum/cout/ovf load from the internal registers.
- DONE -> IDLE unless start = 1. Start in DONE is accepted, which gives back-to-back operation.
- start while busy = 1 is ignored; operand and sub changes during RUN have no effect.
- Arithmetic is modulo 2^WIDTH. Subtract computes a + ~b + 1.
- Counter width is $clog2(WIDTH); it never wraps in RUN.
- Reset values: state = IDLE; busy, done, sum, cout and ovf all 0; internal registers 0.
- Reset mid-operation: async abort to IDLE with all outputs 0 immediately. The first start after rst_n rises is accepted normally.

## Timing
- start sampled at edge 0 -> busy = 1 from edge 0 through edge WIDTH.
- done = 1 for exactly the one cycle after edge WIDTH.
- sum/cout/ovf update at edge WIDTH, coincident with done rising.
- Latency from start to done is WIDTH+1 cycles; maximum throughput is one result per WIDTH+1 cycles.
- busy = 0 in the DONE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package serial_adder_pkg:
  - state typedef (IDLE, RUN, DONE).
  - Mode constants MODE_ADD = 0 and MODE_SUB = 1.
- Sub-module full_adder: a 1-bit a/b/cin -> sum/cout cell, built from two half_adder instances plus an OR gate. serial_adder instantiates it once.
- The FSM, counter, shift registers and output registers live in serial_adder.

## Test plan
- Reset: hold rst_n = 0 with random inputs -> busy, done, sum, cout and ovf are all 0; no done pulse for 20 cycles after release without start.
- Add, WIDTH = 8:
  - a = 8'h3C, b = 8'h55, cin = 0 -> done at cycle 9, sum = 8'h91, cout = 0, ovf = 1.
  - a = 8'hFF, b = 8'h01 -> sum = 8'h00, cout = 1, ovf = 0.
  - cin = 1 with a = 8'h00, b = 8'h00 -> sum = 8'h01.
- Subtract:
  - a = 8'h10, b = 8'h20 -> sum = 8'hF0, cout = 0, ovf = 0.
  - a = 8'h80, b = 8'h01 -> sum = 8'h7F, cout = 1, ovf = 1.
  - cin is ignored in both cases.
- Handshake:
  - Pulse start again at cycle 3 with different operands -> ignored; first result unchanged.
  - Start in the DONE cycle -> second result at exactly 9 cycles later.
  - sum holds its value between operations.
- Reset mid-RUN: assert rst_n at bit 4 -> outputs 0 immediately with no done pulse. A start after release with 8'h01 + 8'h01 -> sum = 8'h02.
- Parameter sweep, WIDTH = 2, 5 and 16: random operands in both modes checked against a + b + cin and a - b, with latency WIDTH+1.
